// File: rtl/fifo_ctrl_pkg.sv
// Shared sizing constants for the 4-entry FIFO controller and its register file.
package fifo_ctrl_pkg;
  localparam int AW_DEF = 2;
  localparam int DEPTH  = 1 << AW_DEF;
  localparam int CNT_W  = AW_DEF + 1;
endpackage

// File: rtl/ptr_cnt.sv
// Wrap-around pointer counter with enable; async active-low reset.
module ptr_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         en,
  output logic [W-1:0] q
);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] q_reg;

  // Natural binary overflow gives the modulo-2^W wrap.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) q_reg <= '0;
    else if (en) q_reg <= q_reg + ONE;
  end

  assign q = q_reg;
endmodule

// File: rtl/regfl_4x8.sv
// 4x8 register file: synchronous write, combinational read so the FIFO can fall through.
module regfl_4x8 (
  input  logic       clk,
  input  logic       wr_e,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [1:0] rd_addr,
  output logic [7:0] rd_data
);
  logic [7:0] mem [4];

  always_ff @(posedge clk) begin
    if (wr_e) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/fifo_ctrl_4.sv
// FWFT FIFO controller driving an external register file.
// Optional sticky overflow/underflow flags with clear: define FIFO_CTRL_ERR_EN.
module fifo_ctrl_4
  import fifo_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          push,
  input  logic          pop,
`ifdef FIFO_CTRL_ERR_EN
  input  logic          clr_err,
  output logic          ovf,
  output logic          udf,
`endif
  output logic          rf_wr_e,
  output logic [AW-1:0] rf_wr_addr,
  output logic [AW-1:0] rf_rd_addr,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   cnt
);
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] CNT_FULL = {1'b1, {AW{1'b0}}};

  logic [AW:0]   cnt_reg;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full  = (cnt_reg == CNT_FULL);
  assign empty = (cnt_reg == '0);

  // rst_b gates the write strobe so nothing lands in the register file during reset.
  assign push_ok = rst_b & push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  ptr_cnt #(.W(AW)) u_wr_ptr (.clk(clk), .rst_b(rst_b), .en(push_ok), .q(wr_ptr));
  ptr_cnt #(.W(AW)) u_rd_ptr (.clk(clk), .rst_b(rst_b), .en(pop_ok),  .q(rd_ptr));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_reg <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   cnt_reg <= cnt_reg + CNT_ONE;
        2'b01:   cnt_reg <= cnt_reg - CNT_ONE;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  logic ovf_reg;
  logic udf_reg;

  // Setting has priority over clearing so an error in the clear cycle is not lost.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ovf_reg <= 1'b0;
      udf_reg <= 1'b0;
    end else begin
      if (push & full & ~pop)    ovf_reg <= 1'b1;
      else if (clr_err)          ovf_reg <= 1'b0;
      if (pop & empty & ~push)   udf_reg <= 1'b1;
      else if (clr_err)          udf_reg <= 1'b0;
    end
  end

  assign ovf = ovf_reg;
  assign udf = udf_reg;
`endif

  assign rf_wr_e    = push_ok;
  assign rf_wr_addr = wr_ptr;
  assign rf_rd_addr = rd_ptr;
  assign cnt        = cnt_reg;
endmodule

// File: tb/tb_fifo_ctrl_4.sv
// Bench for fifo_ctrl_4 + regfl_4x8: directed scenarios, then random traffic against a queue model.
module tb_fifo_ctrl_4;
  logic       clk = 1'b0;
  logic       rst_b;
  logic       push;
  logic       pop;
  logic [7:0] wr_data;
  logic       rf_wr_e;
  logic [1:0] rf_wr_addr;
  logic [1:0] rf_rd_addr;
  logic       full;
  logic       empty;
  logic [2:0] cnt;
  logic [7:0] rd_data;
  logic       clr_err;
`ifdef FIFO_CTRL_ERR_EN
  logic       ovf;
  logic       udf;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: occupancy as a queue, pointers as running transfer totals.
  logic [7:0] mdl_q [$];
  int         mdl_pushes;
  int         mdl_pops;
  bit         mdl_ovf;
  bit         mdl_udf;

  always #5 clk = ~clk;

  fifo_ctrl_4 #(.AW(2)) dut (
    .clk(clk), .rst_b(rst_b), .push(push), .pop(pop),
`ifdef FIFO_CTRL_ERR_EN
    .clr_err(clr_err), .ovf(ovf), .udf(udf),
`endif
    .rf_wr_e(rf_wr_e), .rf_wr_addr(rf_wr_addr), .rf_rd_addr(rf_rd_addr),
    .full(full), .empty(empty), .cnt(cnt)
  );

  regfl_4x8 u_rf (
    .clk(clk), .wr_e(rf_wr_e), .wr_addr(rf_wr_addr), .wr_data(wr_data),
    .rd_addr(rf_rd_addr), .rd_data(rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mdl_q.delete();
    mdl_pushes = 0;
    mdl_pops   = 0;
    mdl_ovf    = 1'b0;
    mdl_udf    = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".cnt"},     32'(cnt),        32'(mdl_q.size()));
    check({tag, ".full"},    32'(full),       32'(mdl_q.size() == 4));
    check({tag, ".empty"},   32'(empty),      32'(mdl_q.size() == 0));
    check({tag, ".wr_addr"}, 32'(rf_wr_addr), 32'(mdl_pushes % 4));
    check({tag, ".rd_addr"}, 32'(rf_rd_addr), 32'(mdl_pops % 4));
    if (mdl_q.size() > 0) check({tag, ".rd_data"}, 32'(rd_data), 32'(mdl_q[0]));
`ifdef FIFO_CTRL_ERR_EN
    check({tag, ".ovf"}, 32'(ovf), 32'(mdl_ovf));
    check({tag, ".udf"}, 32'(udf), 32'(mdl_udf));
`endif
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input string tag, input logic p, input logic o,
                      input logic [7:0] d, input logic c);
    int  occ;
    bit  push_acc;
    bit  pop_acc;
    occ      = mdl_q.size();
    push_acc = p && (occ < 4 || o);
    pop_acc  = o && occ > 0;
    push = p; pop = o; wr_data = d; clr_err = c;
    #1;
    check({tag, ".wr_e"}, 32'(rf_wr_e), 32'(push_acc));
    @(posedge clk);
    if (pop_acc) begin
      void'(mdl_q.pop_front());
      mdl_pops++;
    end
    if (push_acc) begin
      mdl_q.push_back(d);
      mdl_pushes++;
    end
    if (p && occ == 4 && !o) mdl_ovf = 1'b1;
    else if (c)              mdl_ovf = 1'b0;
    if (o && occ == 0 && !p) mdl_udf = 1'b1;
    else if (c)              mdl_udf = 1'b0;
    @(negedge clk);
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    $display("[TB] %s push=%b pop=%b data=%h cnt=%0d", tag, p, o, d, cnt);
    check_state(tag);
  endtask

  initial begin
    logic [7:0] init_words [4];
    logic [7:0] expect_out [4];
    init_words = '{8'hA2, 8'h2E, 8'h98, 8'h55};
    expect_out = '{8'h2E, 8'h98, 8'h55, 8'h20};

    rst_b = 1'b0; push = 1'b1; pop = 1'b0; wr_data = 8'h00; clr_err = 1'b0;
    model_reset();
    #12;
    check("rst.wr_e_held", 32'(rf_wr_e), 32'd0);
    check_state("rst");
    push = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;

    // Fill to full.
    for (int i = 0; i < 4; i++) step("fill", 1'b1, 1'b0, init_words[i], 1'b0);
    check("fill.full_cnt", 32'(cnt), 32'd4);
    check("fill.head", 32'(rd_data), 32'hA2);

    // Push on full without pop is dropped.
    step("drop", 1'b1, 1'b0, 8'hFF, 1'b0);

    // Push and pop together on full.
    step("pushpop_full", 1'b1, 1'b1, 8'h20, 1'b0);
    check("pushpop_full.head", 32'(rd_data), 32'h2E);

    // Drain and verify order, including the word written into slot 0.
    for (int i = 0; i < 4; i++) begin
      check("drain.word", 32'(rd_data), 32'(expect_out[i]));
      step("drain", 1'b0, 1'b1, 8'h00, 1'b0);
    end
    check("drain.rd_wrap", 32'(rf_rd_addr), 32'd1);

    // Push with pop on empty enqueues only; then pop, then pop on empty.
    step("push_empty_pop", 1'b1, 1'b1, 8'hC7, 1'b0);
    check("push_empty_pop.head", 32'(rd_data), 32'hC7);
    step("pop_last", 1'b0, 1'b1, 8'h00, 1'b0);
    step("pop_empty", 1'b0, 1'b1, 8'h00, 1'b0);

    // Clear the sticky flags.
    step("clr", 1'b0, 1'b0, 8'h00, 1'b1);

    // Mid-stream asynchronous reset with three words stored.
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    step("pre_rst_err", 1'b0, 1'b0, 8'h00, 1'b0);
    check("pre_rst.cnt", 32'(cnt), 32'd3);
    #1 rst_b = 1'b0; push = 1'b1;
    #1;
    model_reset();
    check("async_rst.wr_e", 32'(rf_wr_e), 32'd0);
    check_state("async_rst");
    #4 rst_b = 1'b1;
    push = 1'b0;
    @(negedge clk);
    check_state("post_rst");

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom), 1'($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
